// File: rtl/score_board_pkg.sv
// Shared types for the issue-hazard scoreboard: register address, operand
// source select, shadow pipeline entry and the priority-slot mapping.
package score_board_pkg;

    localparam int ISSUE_WIDTH = 2;
    localparam int REG_COUNT   = 32;
    localparam int REG_AW      = 5;
    localparam int NUM_PORTS   = 2 * ISSUE_WIDTH;
    localparam int NUM_ENTRIES = 3 * ISSUE_WIDTH;

    typedef logic [REG_AW-1:0] reg_addr_t;

    typedef enum logic [2:0] {
        SB_REGFILE = 3'd0,
        SB_EX0     = 3'd1,
        SB_EX1     = 3'd2,
        SB_MEM0    = 3'd3,
        SB_MEM1    = 3'd4,
        SB_CMT0    = 3'd5,
        SB_CMT1    = 3'd6
    } sb_data_e;

    typedef struct packed {
        logic      valid;
        reg_addr_t dst;
        logic      is_load;
    } sb_entry_t;

    // Entries reach the resolver sorted youngest first: index 0 is EX1,
    // index 5 is CMT0. This maps a priority index back to its select code.
    function automatic sb_data_e entry_sel(input int idx);
        case (idx)
            0:       return SB_EX1;
            1:       return SB_EX0;
            2:       return SB_MEM1;
            3:       return SB_MEM0;
            4:       return SB_CMT1;
            default: return SB_CMT0;
        endcase
    endfunction

endpackage

// File: rtl/score_board_if.sv
// Issue-queue <-> scoreboard bundle: queue-head candidates in, issue count,
// bypass selects and status out.
interface score_board_if;
    import score_board_pkg::*;

    logic [1:0]                  iq_size;
    reg_addr_t [NUM_PORTS-1:0]   cand_src_addr;
    logic [NUM_PORTS-1:0]        cand_src_ena;
    reg_addr_t [ISSUE_WIDTH-1:0] cand_dst_addr;
    logic [ISSUE_WIDTH-1:0]      cand_dst_ena;
    logic [ISSUE_WIDTH-1:0]      cand_is_load;
    logic                        flush;

    logic [1:0]                  issue_number;
    sb_data_e [NUM_PORTS-1:0]    score_board_data;
    logic [REG_COUNT-1:0]        busy_mask;
    logic [31:0]                 stall_cycles;

    // Queue / issue-stage side
    modport master (
        output iq_size, cand_src_addr, cand_src_ena, cand_dst_addr,
               cand_dst_ena, cand_is_load, flush,
        input  issue_number, score_board_data, busy_mask, stall_cycles
    );

    // Scoreboard side
    modport slave (
        input  iq_size, cand_src_addr, cand_src_ena, cand_dst_addr,
               cand_dst_ena, cand_is_load, flush,
        output issue_number, score_board_data, busy_mask, stall_cycles
    );
endinterface

// File: rtl/score_board_sb_resolve.sv
// Per-read-port source resolver: finds the youngest in-flight writer of one
// source register and flags a load-use hazard when that writer is a load in EX.
module sb_resolve
    import score_board_pkg::*;
(
    input  reg_addr_t                   src_addr,
    input  logic                        src_ena,
    input  sb_entry_t [NUM_ENTRIES-1:0] entries,   // youngest first
    output sb_data_e                    sel,
    output logic                        load_use
);

    // Scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        // NOTE: every output gets a default before any branch, so no path
        // leaves it unassigned and no latch is inferred.
        sel      = SB_REGFILE;
        load_use = 1'b0;
        if (src_ena && (src_addr != '0)) begin
            for (int p = NUM_ENTRIES - 1; p >= 0; p--) begin
                if (entries[p].valid && (entries[p].dst == src_addr)) begin
                    sel      = entry_sel(p);
                    load_use = (p < ISSUE_WIDTH) && entries[p].is_load;
                end
            end
        end
    end

endmodule

// File: rtl/score_board.sv
// Dual-issue hazard controller: shadow EX/MEM/CMT destination tracking,
// in-order issue decision, bypass selects, busy mask and stall counter.
module score_board
    import score_board_pkg::*;
(
    input  logic         clk,
    input  logic         rst,     // synchronous, active low
    score_board_if.slave bus
);

    sb_entry_t [ISSUE_WIDTH-1:0] ex_q, ex_d, mem_q, mem_d, cmt_q, cmt_d;
    logic [31:0]                 stall_q, stall_d;

    sb_entry_t [NUM_ENTRIES-1:0] prio_entries;
    sb_data_e [NUM_PORTS-1:0]    port_sel;
    logic [NUM_PORTS-1:0]        port_lu;

    logic [1:0] iq_eff;
    logic       slot0_raw;
    logic       issue0, issue1;

    // Youngest first: EX1, EX0, MEM1, MEM0, CMT1, CMT0.
    assign prio_entries = {cmt_q[0], cmt_q[1], mem_q[0], mem_q[1], ex_q[0], ex_q[1]};

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_res
        sb_resolve u_res (
            .src_addr (bus.cand_src_addr[g]),
            .src_ena  (bus.cand_src_ena[g]),
            .entries  (prio_entries),
            .sel      (port_sel[g]),
            .load_use (port_lu[g])
        );
    end

    // Issue decision: slot0 blocks on load-use or flush, slot1 also on RAW against slot0.
    always_comb begin
        iq_eff    = (bus.iq_size == 2'd3) ? 2'd2 : bus.iq_size;
        slot0_raw = 1'b0;
        for (int s = ISSUE_WIDTH; s < NUM_PORTS; s++) begin
            if (bus.cand_src_ena[s] && (bus.cand_src_addr[s] != '0) &&
                bus.cand_dst_ena[0] && (bus.cand_dst_addr[0] != '0) &&
                (bus.cand_src_addr[s] == bus.cand_dst_addr[0])) begin
                slot0_raw = 1'b1;
            end
        end
        issue0 = rst && (iq_eff >= 2'd1) && !port_lu[0] && !port_lu[1] && !bus.flush;
        issue1 = issue0 && (iq_eff == 2'd2) && !port_lu[2] && !port_lu[3] && !slot0_raw;
        bus.issue_number = 2'(issue0) + 2'(issue1);
    end

    // Outputs held quiet while reset is asserted.
    always_comb begin
        bus.busy_mask = '0;
        for (int e = 0; e < NUM_ENTRIES; e++) begin
            if (prio_entries[e].valid) begin
                bus.busy_mask[prio_entries[e].dst] = 1'b1;
            end
        end
        if (!rst) begin
            bus.busy_mask = '0;
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            bus.score_board_data[p] = rst ? port_sel[p] : SB_REGFILE;
        end
        bus.stall_cycles = stall_q;
    end

    // Next shadow state: issued slots enter EX, older stages shift, flush empties all.
    always_comb begin
        for (int s = 0; s < ISSUE_WIDTH; s++) begin
            ex_d[s].valid   = ((s == 0) ? issue0 : issue1) &&
                              bus.cand_dst_ena[s] && (bus.cand_dst_addr[s] != '0);
            ex_d[s].dst     = bus.cand_dst_addr[s];
            ex_d[s].is_load = bus.cand_is_load[s];
        end
        mem_d   = bus.flush ? '0 : ex_q;
        cmt_d   = bus.flush ? '0 : mem_q;
        stall_d = stall_q + 32'((bus.issue_number < iq_eff) && !bus.flush);
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples its pre-edge inputs regardless of statement order.
        if (!rst) begin
            ex_q    <= '0;
            mem_q   <= '0;
            cmt_q   <= '0;
            stall_q <= '0;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            cmt_q   <= cmt_d;
            stall_q <= stall_d;
        end
    end

endmodule

// File: tb/tb_score_board.sv
// Directed bench for score_board: reset, independent pair, intra-pair RAW,
// load-use, select priority, register $0, flush and mid-run reset.
module tb_score_board;
    import score_board_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    score_board_if sb_if ();

    score_board dut (
        .clk (clk),
        .rst (rst),
        .bus (sb_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_sel(input string tag, input int port, input sb_data_e exp);
        check(tag, 32'(sb_if.score_board_data[port]), 32'(exp));
    endtask

    task automatic check_all_regfile(input string tag);
        for (int p = 0; p < NUM_PORTS; p++) begin
            check_sel(tag, p, SB_REGFILE);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive queue head: slot0 d0 <- s0a,s0b ; slot1 d1 <- s1a,s1b.
    task automatic drive(input logic [1:0] n,
                         input int s0a, input int s0b, input int d0, input logic ld0,
                         input int s1a, input int s1b, input int d1, input logic ld1);
        sb_if.iq_size          = n;
        sb_if.cand_src_addr[0] = 5'(s0a);
        sb_if.cand_src_addr[1] = 5'(s0b);
        sb_if.cand_src_addr[2] = 5'(s1a);
        sb_if.cand_src_addr[3] = 5'(s1b);
        sb_if.cand_src_ena     = 4'hf;
        sb_if.cand_dst_addr[0] = 5'(d0);
        sb_if.cand_dst_addr[1] = 5'(d1);
        sb_if.cand_dst_ena     = 2'b11;
        sb_if.cand_is_load     = {ld1, ld0};
    endtask

    task automatic idle();
        drive(2'd0, 0, 0, 0, 1'b0, 0, 0, 0, 1'b0);
    endtask

    initial begin
        sb_if.flush = 1'b0;

        // Reset held for two edges with a full queue head
        drive(2'd2, 1, 2, 3, 1'b0, 4, 6, 5, 1'b0);
        #2;
        check("rst_issue", 32'(sb_if.issue_number), 32'd0);
        check("rst_busy", sb_if.busy_mask, 32'h0);
        check_all_regfile("rst_sel");
        tick();
        tick();
        check("rst_stall", sb_if.stall_cycles, 32'd0);
        check("rst_busy2", sb_if.busy_mask, 32'h0);

        // Independent pair issues in the first rst-high cycle
        rst = 1'b1;
        #1;
        check("pair_issue", 32'(sb_if.issue_number), 32'd2);
        check_all_regfile("pair_sel");
        tick();
        idle();
        #1;
        check("pair_busy_ex", sb_if.busy_mask, 32'h28);
        tick();
        tick();
        check("pair_busy_cmt", sb_if.busy_mask, 32'h28);
        tick();
        check("pair_busy_gone", sb_if.busy_mask, 32'h0);
        check("pair_stall", sb_if.stall_cycles, 32'd0);

        // Intra-pair RAW: slot1 reads slot0's $3
        drive(2'd2, 1, 2, 3, 1'b0, 3, 4, 7, 1'b0);
        #1;
        check("raw_issue", 32'(sb_if.issue_number), 32'd1);
        tick();
        check("raw_stall", sb_if.stall_cycles, 32'd1);
        drive(2'd2, 3, 4, 7, 1'b0, 11, 12, 10, 1'b0);
        #1;
        check_sel("raw_fwd_ex0", 0, SB_EX0);
        check_sel("raw_fwd_rf", 1, SB_REGFILE);
        check("raw_issue2", 32'(sb_if.issue_number), 32'd2);
        tick();

        // Load-use on $8: one bubble, then forwarded from MEM0
        drive(2'd1, 1, 2, 8, 1'b1, 0, 0, 0, 1'b0);
        #1;
        check("ld_issue", 32'(sb_if.issue_number), 32'd1);
        tick();
        drive(2'd1, 8, 1, 13, 1'b0, 0, 0, 0, 1'b0);
        #1;
        check("lu_issue", 32'(sb_if.issue_number), 32'd0);
        check_sel("lu_sel_ex0", 0, SB_EX0);
        tick();
        check("lu_stall", sb_if.stall_cycles, 32'd2);
        check("lu_issue_after", 32'(sb_if.issue_number), 32'd1);
        check_sel("lu_sel_mem0", 0, SB_MEM0);
        tick();

        // Priority: EX0 and MEM1 both hold $9
        drive(2'd2, 1, 2, 20, 1'b0, 1, 2, 9, 1'b0);
        #1;
        check("prio_pair_issue", 32'(sb_if.issue_number), 32'd2);
        tick();
        drive(2'd1, 1, 2, 9, 1'b0, 0, 0, 0, 1'b0);
        #1;
        check("prio_single_issue", 32'(sb_if.issue_number), 32'd1);
        tick();
        drive(2'd0, 9, 0, 21, 1'b0, 0, 0, 0, 1'b0);
        #1;
        check_sel("prio_ex0_over_mem1", 0, SB_EX0);
        check_sel("prio_src0_rf", 1, SB_REGFILE);
        tick();

        // Priority: WAW pair puts $9 in EX1 and EX0
        drive(2'd2, 1, 2, 9, 1'b0, 1, 2, 9, 1'b0);
        #1;
        check("waw_issue", 32'(sb_if.issue_number), 32'd2);
        tick();
        drive(2'd0, 9, 0, 21, 1'b0, 0, 0, 0, 1'b0);
        #1;
        check_sel("prio_ex1_over_ex0", 0, SB_EX1);
        check("waw_busy", sb_if.busy_mask, 32'h200);
        tick();

        // Register $0: a write to $0 is never tracked or matched
        drive(2'd1, 1, 2, 0, 1'b0, 0, 0, 0, 1'b0);
        #1;
        check("zero_issue", 32'(sb_if.issue_number), 32'd1);
        tick();
        drive(2'd0, 0, 0, 21, 1'b0, 0, 0, 0, 1'b0);
        #1;
        check_sel("zero_src_rf", 0, SB_REGFILE);
        check("zero_busy", sb_if.busy_mask, 32'h200);
        tick();
        tick();

        // Flush with four entries in flight
        drive(2'd2, 1, 2, 3, 1'b0, 4, 6, 5, 1'b0);
        tick();
        drive(2'd2, 1, 2, 7, 1'b0, 1, 2, 8, 1'b0);
        tick();
        check("fl_busy_before", sb_if.busy_mask, 32'h1a8);
        drive(2'd2, 1, 2, 11, 1'b0, 1, 2, 12, 1'b0);
        sb_if.flush = 1'b1;
        #1;
        check("fl_issue", 32'(sb_if.issue_number), 32'd0);
        tick();
        sb_if.flush = 1'b0;
        drive(2'd0, 7, 3, 21, 1'b0, 8, 5, 22, 1'b0);
        #1;
        check("fl_busy_after", sb_if.busy_mask, 32'h0);
        check_all_regfile("fl_sel");
        check("fl_stall", sb_if.stall_cycles, 32'd2);

        // Reset mid-operation, then iq_size=3 treated as 2
        drive(2'd2, 1, 2, 3, 1'b0, 4, 6, 5, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        check("mrst_busy", sb_if.busy_mask, 32'h0);
        check("mrst_issue", 32'(sb_if.issue_number), 32'd0);
        tick();
        rst = 1'b1;
        drive(2'd3, 3, 5, 6, 1'b0, 1, 2, 7, 1'b0);
        #1;
        check("mrst_busy_after", sb_if.busy_mask, 32'h0);
        check("mrst_stall", sb_if.stall_cycles, 32'd0);
        check_sel("mrst_sel", 0, SB_REGFILE);
        check("iq3_issue", 32'(sb_if.issue_number), 32'd2);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
